// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - command encodings presented on the op port
//   - FSM state encoding
//   - iteration count of the shift-add / restoring-divide loop
package mdu_pkg;

    localparam logic [2:0] MDU_NOP  = 3'b000;
    localparam logic [2:0] MDU_MUL  = 3'b001;
    localparam logic [2:0] MDU_DIV  = 3'b010;
    localparam logic [2:0] MDU_MTHI = 3'b011;
    localparam logic [2:0] MDU_MTLO = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    localparam int ITER = 32;

endpackage : mdu_pkg

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate.
// Ports:
//   din  - value to pass through or negate
//   neg  - 1 = output -din, 0 = output din
//   dout - result (combinational)
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Negate by invert-and-increment when requested.
    always_comb begin
        dout = din;
        if (neg) begin
            dout = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            dout = din;
        end
    end

endmodule : mdu_signfix

// File: rtl/mdu_iterative.sv
// Multi-cycle MIPS multiply/divide unit with the HI/LO register pair.
// MUL runs an unsigned shift-add, DIV a restoring divide, both on operand
// magnitudes for 32 iterations; a final FIX cycle applies the sign and writes
// HI/LO atomically.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   op    - command (NOP/MUL/DIV/MTHI/MTLO), start - command valid
//   Sign  - 1 = signed operation
//   A, B  - operands (A is also the MTHI/MTLO source)
//   busy  - MUL/DIV in progress, done - one-cycle result pulse
//   hi, lo - HI and LO registers
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q;
    logic               sa_q, sb_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH-1:0]   rem_diff_s;

    mdu_signfix #(.WIDTH(WIDTH)) u_mag_a (
        .din (A),
        .neg (Sign & A[WIDTH-1]),
        .dout(a_mag_s)
    );

    mdu_signfix #(.WIDTH(WIDTH)) u_mag_b (
        .din (B),
        .neg (Sign & B[WIDTH-1]),
        .dout(b_mag_s)
    );

    mdu_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .din (acc_q),
        .neg (sa_q ^ sb_q),
        .dout(prod_s)
    );

    mdu_signfix #(.WIDTH(WIDTH)) u_fix_quo (
        .din (acc_q[WIDTH-1:0]),
        .neg (sa_q ^ sb_q),
        .dout(quo_s)
    );

    // Remainder follows the dividend's sign.
    mdu_signfix #(.WIDTH(WIDTH)) u_fix_rem (
        .din (acc_q[2*WIDTH-1:WIDTH]),
        .neg (sa_q),
        .dout(rem_s)
    );

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        // Shifted partial remainder: one extra bit, because it can reach
        // 2*|B|-1 when the divisor has its top bit set.
        rem_shift_s = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        // Only used when the trial subtract succeeds, so the result fits.
        rem_diff_s  = rem_shift_s[WIDTH-1:0] - b_q;
        if (is_div_q) begin
            a_d = {a_q[WIDTH-2:0], 1'b0};
            if (rem_shift_s >= {1'b0, b_q}) begin
                acc_d = {rem_diff_s, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            b_d = {1'b0, b_q[WIDTH-1:1]};
            if (b_q[0]) begin
                acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    // Control FSM, iteration datapath registers and HI/LO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MUL, MDU_DIV: begin
                                a_q      <= a_mag_s;
                                b_q      <= b_mag_s;
                                is_div_q <= (op == MDU_DIV);
                                sa_q     <= Sign & A[WIDTH-1];
                                sb_q     <= Sign & B[WIDTH-1];
                                acc_q    <= {(2*WIDTH){1'b0}};
                                cnt_q    <= {CNT_W{1'b0}};
                                state_q  <= CALC;
                            end
                            MDU_MTHI: hi_q <= A;
                            MDU_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_s;
                        lo_q <= quo_s;
                    end else begin
                        hi_q <= prod_s[2*WIDTH-1:WIDTH];
                        lo_q <= prod_s[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : mdu_iterative

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

    logic        clk;
    logic        reset;
    logic [2:0]  op;
    logic        start;
    logic        Sign;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    mdu_iterative dut (
        .clk  (clk),
        .reset(reset),
        .op   (op),
        .start(start),
        .Sign (Sign),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a MUL/DIV at the next edge, then follow it to the done pulse.
    task automatic run_md(input string tag, input logic [2:0] o, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        int          nb;
        int          held;
        @(negedge clk);
        old_hi = hi;
        old_lo = lo;
        op = o; Sign = s; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        n = 0; nb = 0; held = 1;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (hi !== old_hi || lo !== old_lo) held = 0;
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".done"}, 64'(done), 64'd1);
        check_eq({tag, ".lat"}, 64'(n), 64'd33);
        check_eq({tag, ".busycyc"}, 64'(nb), 64'd33);
        check_eq({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, ".held"}, 64'(held), 64'd1);
        check_eq({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        n_cmp = 0; n_err = 0;
        reset = 1'b0; op = 3'b000; start = 1'b0; Sign = 1'b0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst.hi", 64'(hi), 64'd0);
        check_eq("rst.lo", 64'(lo), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        reset = 1'b1;

        run_md("mul_s_m3x5", 3'b001, 1'b1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_md("mul_u_max", 3'b001, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("mul_s_m1", 3'b001, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_md("div_s_m7d2", 3'b010, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_u_7d2", 3'b010, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
        run_md("div_u_by0", 3'b010, 1'b0, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_md("div_s_m7by0", 3'b010, 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'h00000001);
        run_md("div_s_ovf", 3'b010, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_md("div_u_big", 3'b010, 1'b0, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001);

        // MTHI then MTLO back to back
        @(negedge clk);
        op = 3'b011; A = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        check_eq("mthi.hi", 64'(hi), 64'hDEADBEEF);
        check_eq("mthi.busy", 64'(busy), 64'd0);
        check_eq("mthi.done", 64'(done), 64'd0);
        op = 3'b100; A = 32'h00000001;
        @(negedge clk);
        check_eq("mtlo.lo", 64'(lo), 64'h1);
        check_eq("mtlo.hi", 64'(hi), 64'hDEADBEEF);
        check_eq("mtlo.busy", 64'(busy), 64'd0);
        check_eq("mtlo.done", 64'(done), 64'd0);

        // NOP and undefined ops leave everything alone
        op = 3'b000; A = 32'h55555555;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        check_eq("nop.hi", 64'(hi), 64'hDEADBEEF);
        check_eq("nop.lo", 64'(lo), 64'h1);
        check_eq("nop.busy", 64'(busy), 64'd0);

        // MTHI while a MUL is running is dropped
        op = 3'b001; Sign = 1'b1; A = 32'hFFFFFFFD; B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        op = 3'b011; A = 32'h12121212; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        check_eq("mthi_busy.hi_hold", 64'(hi), 64'hDEADBEEF);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("mthi_busy.done", 64'(done), 64'd1);
        check_eq("mthi_busy.hi", 64'(hi), 64'hFFFFFFFF);
        check_eq("mthi_busy.lo", 64'(lo), 64'hFFFFFFF1);

        // Reset in the middle of a DIV
        @(negedge clk);
        op = 3'b010; Sign = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'b000;
        repeat (9) @(negedge clk);
        check_eq("rstdiv.busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("rstdiv.busy", 64'(busy), 64'd0);
        check_eq("rstdiv.done", 64'(done), 64'd0);
        check_eq("rstdiv.hi", 64'(hi), 64'd0);
        check_eq("rstdiv.lo", 64'(lo), 64'd0);
        run_md("mul_after_rst", 3'b001, 1'b0, 32'h00010000, 32'h00010003, 32'h00000001, 32'h00030000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mdu_iterative
